// File: rtl/recover_unit_n.sv
// Branch/jump recovery unit: picks the oldest redirecting issue slot, holds the
// redirect until the PC unit acknowledges it, then masks new input for a shadow window.
module recover_unit_n #(
    parameter int unsigned ISSUE_W    = 2,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHADOW_CYC = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [ISSUE_W-1:0]        slot_valid,
    input  logic [ISSUE_W-1:0]        is_branch,
    input  logic [ISSUE_W-1:0]        is_jump,
    input  logic [ISSUE_W-1:0]        taken,
    input  logic [ISSUE_W-1:0]        pred_taken,
    input  logic [ISSUE_W*XLEN-1:0]   target_pc,
    input  logic [ISSUE_W*XLEN-1:0]   original_pc,
    input  logic                      recover_ack,
    output logic                      recover_en,
    output logic [XLEN-1:0]           recover_pc,
    output logic                      branch_predict_miss,
    output logic [ISSUE_W-1:0]        flush_onehot,
    output logic [ISSUE_W-1:0]        kill_mask,
    output logic [CNT_W-1:0]          miss_count,
    output logic                      busy
);

    localparam int unsigned SH_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SHADOW = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_recover_en;
    logic [XLEN-1:0]     r_recover_pc;
    logic                r_miss;
    logic [ISSUE_W-1:0]  r_flush;
    logic [ISSUE_W-1:0]  r_kill;
    logic [CNT_W-1:0]    r_miss_count;
    logic                r_busy;
    logic [SH_W-1:0]     r_shadow_cnt;

    logic                w_recover_en_nxt;
    logic [XLEN-1:0]     w_recover_pc_nxt;
    logic                w_miss_nxt;
    logic [ISSUE_W-1:0]  w_flush_nxt;
    logic [ISSUE_W-1:0]  w_kill_nxt;
    logic [CNT_W-1:0]    w_miss_count_nxt;
    logic                w_busy_nxt;
    logic [SH_W-1:0]     w_shadow_cnt_nxt;

    logic                w_done;
    logic                w_hit;
    logic [XLEN-1:0]     w_hit_pc;
    logic                w_hit_miss;
    logic [ISSUE_W-1:0]  w_hit_flush;
    logic [ISSUE_W-1:0]  w_hit_kill;

    // Oldest-first scan; a correctly predicted taken branch ends the scan silently.
    always_comb begin
        w_done      = 1'b0;
        w_hit       = 1'b0;
        w_hit_pc    = '0;
        w_hit_miss  = 1'b0;
        w_hit_flush = '0;
        for (int i = 0; i < int'(ISSUE_W); i++) begin
            if (!w_done && slot_valid[i]) begin
                if (is_jump[i] || (is_branch[i] && taken[i] && !pred_taken[i])) begin
                    w_done      = 1'b1;
                    w_hit       = 1'b1;
                    w_hit_pc    = target_pc[i*XLEN +: XLEN];
                    w_hit_miss  = !is_jump[i];
                    w_hit_flush = ISSUE_W'(1) << i;
                end else if (is_branch[i] && !taken[i] && pred_taken[i]) begin
                    w_done      = 1'b1;
                    w_hit       = 1'b1;
                    w_hit_pc    = original_pc[i*XLEN +: XLEN] + XLEN'(4);
                    w_hit_miss  = 1'b1;
                    w_hit_flush = ISSUE_W'(1) << i;
                end else if (is_branch[i] && taken[i]) begin
                    w_done = 1'b1;
                end
            end
        end
        // Every bit above the flushed slot; yields zero when nothing is flushed.
        w_hit_kill = ~((w_hit_flush << 1) - ISSUE_W'(1));
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_recover_en_nxt = r_recover_en;
        w_recover_pc_nxt = r_recover_pc;
        w_miss_nxt       = r_miss;
        w_flush_nxt      = r_flush;
        w_kill_nxt       = r_kill;
        w_miss_count_nxt = r_miss_count;
        w_shadow_cnt_nxt = r_shadow_cnt;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_state_nxt      = PEND;
                    w_recover_en_nxt = 1'b1;
                    w_recover_pc_nxt = w_hit_pc;
                    w_miss_nxt       = w_hit_miss;
                    w_flush_nxt      = w_hit_flush;
                    w_kill_nxt       = w_hit_kill;
                    if (w_hit_miss && (r_miss_count != '1)) begin
                        w_miss_count_nxt = r_miss_count + CNT_W'(1);
                    end
                end
            end
            PEND: begin
                if (recover_ack) begin
                    w_recover_en_nxt = 1'b0;
                    w_recover_pc_nxt = '0;
                    w_miss_nxt       = 1'b0;
                    w_flush_nxt      = '0;
                    w_kill_nxt       = '0;
                    if (SHADOW_CYC == 0) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt      = SHADOW;
                        w_shadow_cnt_nxt = SH_W'(SHADOW_CYC - 1);
                    end
                end
            end
            SHADOW: begin
                if (r_shadow_cnt == '0) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_shadow_cnt_nxt = r_shadow_cnt - SH_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_recover_en <= 1'b0;
            r_recover_pc <= '0;
            r_miss       <= 1'b0;
            r_flush      <= '0;
            r_kill       <= '0;
            r_miss_count <= '0;
            r_busy       <= 1'b0;
            r_shadow_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_recover_en <= w_recover_en_nxt;
            r_recover_pc <= w_recover_pc_nxt;
            r_miss       <= w_miss_nxt;
            r_flush      <= w_flush_nxt;
            r_kill       <= w_kill_nxt;
            r_miss_count <= w_miss_count_nxt;
            r_busy       <= w_busy_nxt;
            r_shadow_cnt <= w_shadow_cnt_nxt;
        end
    end

    assign recover_en          = r_recover_en;
    assign recover_pc          = r_recover_pc;
    assign branch_predict_miss = r_miss;
    assign flush_onehot        = r_flush;
    assign kill_mask           = r_kill;
    assign miss_count          = r_miss_count;
    assign busy                = r_busy;

endmodule

// File: tb/tb_recover_unit_n.sv
// Bench for recover_unit_n: a 2-slot default instance and a 4-slot, 2-bit-counter,
// zero-shadow instance share stimulus and are compared against a behavioural model.
module tb_recover_unit_n;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ack;
    logic [3:0]  s_valid, s_br, s_jmp, s_tk, s_pt;
    logic [31:0] s_tpc [4];
    logic [31:0] s_opc [4];
    logic [63:0]  a_tpc, a_opc;
    logic [127:0] b_tpc, b_opc;

    logic        a_en, a_miss, a_busy;
    logic [31:0] a_pc;
    logic [1:0]  a_flush, a_kill;
    logic [15:0] a_cnt;
    logic        b_en, b_miss, b_busy;
    logic [31:0] b_pc;
    logic [3:0]  b_flush, b_kill;
    logic [1:0]  b_cnt;

    int n_err = 0;
    int n_chk = 0;

    // Model state per instance: 0 = idle, 1 = pending redirect, 2 = shadow.
    int          m_state [2];
    int          m_left  [2];
    int          m_cnt   [2];
    logic        m_en    [2];
    logic        m_miss  [2];
    logic [31:0] m_pc    [2];
    logic [3:0]  m_flush [2];
    logic [3:0]  m_kill  [2];

    always #5 clk = ~clk;

    assign a_tpc = {s_tpc[1], s_tpc[0]};
    assign a_opc = {s_opc[1], s_opc[0]};
    assign b_tpc = {s_tpc[3], s_tpc[2], s_tpc[1], s_tpc[0]};
    assign b_opc = {s_opc[3], s_opc[2], s_opc[1], s_opc[0]};

    recover_unit_n #(.ISSUE_W(2), .XLEN(32), .SHADOW_CYC(2), .CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn), .slot_valid(s_valid[1:0]), .is_branch(s_br[1:0]),
        .is_jump(s_jmp[1:0]), .taken(s_tk[1:0]), .pred_taken(s_pt[1:0]),
        .target_pc(a_tpc), .original_pc(a_opc), .recover_ack(ack),
        .recover_en(a_en), .recover_pc(a_pc), .branch_predict_miss(a_miss),
        .flush_onehot(a_flush), .kill_mask(a_kill), .miss_count(a_cnt), .busy(a_busy)
    );

    recover_unit_n #(.ISSUE_W(4), .XLEN(32), .SHADOW_CYC(0), .CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn), .slot_valid(s_valid), .is_branch(s_br),
        .is_jump(s_jmp), .taken(s_tk), .pred_taken(s_pt),
        .target_pc(b_tpc), .original_pc(b_opc), .recover_ack(ack),
        .recover_en(b_en), .recover_pc(b_pc), .branch_predict_miss(b_miss),
        .flush_onehot(b_flush), .kill_mask(b_kill), .miss_count(b_cnt), .busy(b_busy)
    );

    // Oldest-first redirect decision over the first n slots.
    function automatic void scan(input int n, output bit hit, output logic [31:0] pc,
                                 output bit miss, output int slot);
        hit = 0; pc = '0; miss = 0; slot = 0;
        for (int i = 0; i < n; i++) begin
            if (!s_valid[i]) continue;
            if (s_jmp[i]) begin hit = 1; pc = s_tpc[i]; slot = i; return; end
            if (s_br[i]) begin
                if (s_tk[i] && !s_pt[i]) begin hit = 1; miss = 1; pc = s_tpc[i]; slot = i; return; end
                if (!s_tk[i] && s_pt[i]) begin hit = 1; miss = 1; pc = s_opc[i] + 32'd4; slot = i; return; end
                if (s_tk[i]) return;
            end
        end
    endfunction

    task automatic model_step();
        bit hit, miss;
        logic [31:0] pc;
        int slot, n, sc, cmax;
        for (int d = 0; d < 2; d++) begin
            n    = (d == 0) ? 2 : 4;
            sc   = (d == 0) ? 2 : 0;
            cmax = (d == 0) ? 65535 : 3;
            if (!rstn) begin
                m_state[d] = 0; m_left[d] = 0; m_cnt[d] = 0; m_en[d] = 0;
                m_miss[d] = 0; m_pc[d] = '0; m_flush[d] = '0; m_kill[d] = '0;
            end else if (m_state[d] == 0) begin
                scan(n, hit, pc, miss, slot);
                if (hit) begin
                    m_state[d] = 1; m_en[d] = 1; m_pc[d] = pc; m_miss[d] = miss;
                    m_flush[d] = 4'(1 << slot);
                    m_kill[d]  = 4'(((1 << n) - 1) & ~((2 << slot) - 1));
                    if (miss && m_cnt[d] < cmax) m_cnt[d]++;
                end
            end else if (m_state[d] == 1) begin
                if (ack) begin
                    m_en[d] = 0; m_pc[d] = '0; m_miss[d] = 0; m_flush[d] = '0; m_kill[d] = '0;
                    m_state[d] = (sc == 0) ? 0 : 2;
                    m_left[d]  = sc;
                end
            end else begin
                m_left[d]--;
                if (m_left[d] == 0) m_state[d] = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        s_valid = '0; s_br = '0; s_jmp = '0; s_tk = '0; s_pt = '0; ack = 1'b0;
        for (int i = 0; i < 4; i++) begin s_tpc[i] = '0; s_opc[i] = '0; end
    endtask

    task automatic drain();
        clr();
        ack = 1'b1; tick(); ack = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        clr(); rstn = 1'b0;
        tick(); tick();
        n_chk++; if (a_en !== 1'b0)    begin n_err++; $display("FAIL rst_a_en: got %0h want 0", a_en); end
        n_chk++; if (a_pc !== 32'd0)   begin n_err++; $display("FAIL rst_a_pc: got %0h want 0", a_pc); end
        n_chk++; if (a_flush !== 2'd0 || a_kill !== 2'd0) begin n_err++; $display("FAIL rst_a_mask: got %0h/%0h want 0/0", a_flush, a_kill); end
        n_chk++; if (a_cnt !== 16'd0 || a_busy !== 1'b0 || a_miss !== 1'b0) begin n_err++; $display("FAIL rst_a_misc: got cnt %0h busy %0h miss %0h want 0", a_cnt, a_busy, a_miss); end
        n_chk++; if (b_en !== 1'b0 || b_cnt !== 2'd0 || b_busy !== 1'b0) begin n_err++; $display("FAIL rst_b: got en %0h cnt %0h busy %0h want 0", b_en, b_cnt, b_busy); end
        rstn = 1'b1;
    endtask

    task automatic test_mispredict_nt();
        clr();
        s_valid = 4'b0001; s_br = 4'b0001; s_pt = 4'b0001; s_opc[0] = 32'h100;
        tick();
        n_chk++; if (a_en !== 1'b1)      begin n_err++; $display("FAIL nt_en: got %0h want 1", a_en); end
        n_chk++; if (a_pc !== 32'h104)   begin n_err++; $display("FAIL nt_pc: got %0h want 104", a_pc); end
        n_chk++; if (a_miss !== 1'b1)    begin n_err++; $display("FAIL nt_miss: got %0h want 1", a_miss); end
        n_chk++; if (a_flush !== 2'b01)  begin n_err++; $display("FAIL nt_flush: got %0b want 01", a_flush); end
        n_chk++; if (a_kill !== 2'b10)   begin n_err++; $display("FAIL nt_kill: got %0b want 10", a_kill); end
        n_chk++; if (a_cnt !== 16'd1)    begin n_err++; $display("FAIL nt_cnt: got %0d want 1", a_cnt); end
        n_chk++; if (b_kill !== 4'b1110) begin n_err++; $display("FAIL nt_b_kill: got %0b want 1110", b_kill); end
        drain();
        n_chk++; if (a_busy !== 1'b0 || a_en !== 1'b0) begin n_err++; $display("FAIL nt_drain: got busy %0h en %0h want 0", a_busy, a_en); end
    endtask

    task automatic test_jump_after_nt();
        clr();
        s_valid = 4'b0011; s_br = 4'b0001; s_jmp = 4'b0010; s_tpc[1] = 32'h2000;
        tick();
        n_chk++; if (a_pc !== 32'h2000)  begin n_err++; $display("FAIL jmp_pc: got %0h want 2000", a_pc); end
        n_chk++; if (a_miss !== 1'b0)    begin n_err++; $display("FAIL jmp_miss: got %0h want 0", a_miss); end
        n_chk++; if (a_flush !== 2'b10 || a_kill !== 2'b00) begin n_err++; $display("FAIL jmp_mask: got %0b/%0b want 10/00", a_flush, a_kill); end
        n_chk++; if (a_cnt !== 16'd1)    begin n_err++; $display("FAIL jmp_cnt: got %0d want 1", a_cnt); end
        n_chk++; if (b_flush !== 4'b0010 || b_kill !== 4'b1100) begin n_err++; $display("FAIL jmp_b_mask: got %0b/%0b want 0010/1100", b_flush, b_kill); end
        drain();
    endtask

    task automatic test_taken_stop();
        clr();
        s_valid = 4'b0011; s_br = 4'b0011; s_tk = 4'b0011; s_pt = 4'b0001; s_tpc[1] = 32'h5000;
        tick(); tick();
        n_chk++; if (a_en !== 1'b0 || a_busy !== 1'b0) begin n_err++; $display("FAIL stop_en: got en %0h busy %0h want 0", a_en, a_busy); end
        n_chk++; if (a_cnt !== 16'd1)    begin n_err++; $display("FAIL stop_cnt: got %0d want 1", a_cnt); end
        n_chk++; if (b_en !== 1'b0)      begin n_err++; $display("FAIL stop_b_en: got %0h want 0", b_en); end
        clr();
    endtask

    task automatic test_pend_hold();
        clr();
        s_valid = 4'b0010; s_br = 4'b0010; s_tk = 4'b0010; s_tpc[1] = 32'h3000;
        tick();
        n_chk++; if (a_en !== 1'b1 || a_pc !== 32'h3000 || a_cnt !== 16'd2) begin n_err++; $display("FAIL hold_cap: got en %0h pc %0h cnt %0d want 1/3000/2", a_en, a_pc, a_cnt); end
        for (int k = 0; k < 5; k++) begin
            clr();
            s_valid = 4'b0001; s_br = 4'b0001; s_pt = 4'b0001; s_opc[0] = $urandom;
            tick();
            n_chk++; if (a_en !== 1'b1 || a_pc !== 32'h3000 || a_flush !== 2'b10 || a_kill !== 2'b00 || a_cnt !== 16'd2)
                begin n_err++; $display("FAIL hold_frz%0d: got en %0h pc %0h fl %0b kl %0b cnt %0d want 1/3000/10/00/2", k, a_en, a_pc, a_flush, a_kill, a_cnt); end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        n_chk++; if (a_en !== 1'b0 || a_busy !== 1'b1 || a_pc !== 32'd0 || a_flush !== 2'd0) begin n_err++; $display("FAIL hold_ack: got en %0h busy %0h pc %0h fl %0b want 0/1/0/0", a_en, a_busy, a_pc, a_flush); end
        tick();
        n_chk++; if (a_busy !== 1'b1 || a_en !== 1'b0) begin n_err++; $display("FAIL hold_sh1: got busy %0h en %0h want 1/0", a_busy, a_en); end
        tick();
        n_chk++; if (a_busy !== 1'b0 || a_en !== 1'b0 || a_cnt !== 16'd2) begin n_err++; $display("FAIL hold_sh2: got busy %0h en %0h cnt %0d want 0/0/2", a_busy, a_en, a_cnt); end
        tick();
        n_chk++; if (a_en !== 1'b1 || a_pc !== s_opc[0] + 32'd4 || a_cnt !== 16'd3) begin n_err++; $display("FAIL hold_recap: got en %0h pc %0h cnt %0d want 1/%0h/3", a_en, a_pc, a_cnt, s_opc[0] + 32'd4); end
        drain();
    endtask

    task automatic test_reset_in_pend();
        clr();
        s_valid = 4'b0001; s_br = 4'b0001; s_pt = 4'b0001; s_opc[0] = 32'h200;
        tick();
        rstn = 1'b0; tick();
        n_chk++; if (a_en !== 1'b0 || a_pc !== 32'd0 || a_miss !== 1'b0 || a_flush !== 2'd0 || a_kill !== 2'd0)
            begin n_err++; $display("FAIL rpend_out: got en %0h pc %0h miss %0h fl %0b kl %0b want 0", a_en, a_pc, a_miss, a_flush, a_kill); end
        n_chk++; if (a_cnt !== 16'd0 || a_busy !== 1'b0) begin n_err++; $display("FAIL rpend_cnt: got cnt %0d busy %0h want 0/0", a_cnt, a_busy); end
        rstn = 1'b1; tick();
        n_chk++; if (a_en !== 1'b1 || a_pc !== 32'h204 || a_cnt !== 16'd1) begin n_err++; $display("FAIL rpend_recap: got en %0h pc %0h cnt %0d want 1/204/1", a_en, a_pc, a_cnt); end
        drain();
    endtask

    task automatic test_saturation();
        clr(); rstn = 1'b0; tick(); rstn = 1'b1;
        for (int k = 0; k < 5; k++) begin
            clr();
            s_valid = 4'b0100; s_br = 4'b0100; s_pt = 4'b0100; s_opc[2] = 32'h400 + 32'(k * 16);
            tick();
            n_chk++; if (b_en !== 1'b1 || b_flush !== 4'b0100 || b_kill !== 4'b1000) begin n_err++; $display("FAIL sat_mask%0d: got en %0h fl %0b kl %0b want 1/0100/1000", k, b_en, b_flush, b_kill); end
            n_chk++; if (b_cnt !== 2'((k + 1 > 3) ? 3 : k + 1)) begin n_err++; $display("FAIL sat_cnt%0d: got %0d want %0d", k, b_cnt, (k + 1 > 3) ? 3 : k + 1); end
            n_chk++; if (a_en !== 1'b0) begin n_err++; $display("FAIL sat_a_en%0d: got %0h want 0", k, a_en); end
            ack = 1'b1; tick(); ack = 1'b0;
            n_chk++; if (b_en !== 1'b0 || b_busy !== 1'b0) begin n_err++; $display("FAIL sat_ack%0d: got en %0h busy %0h want 0/0", k, b_en, b_busy); end
        end
        clr();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            s_valid = 4'($urandom); s_br = 4'($urandom); s_jmp = 4'($urandom & $urandom);
            s_tk = 4'($urandom); s_pt = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                s_tpc[i] = $urandom;
                s_opc[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
            end
            ack  = ($urandom_range(0, 2) == 0);
            rstn = ($urandom_range(0, 49) != 0);
            tick();
            n_chk++; if (a_en !== m_en[0] || a_pc !== m_pc[0] || a_miss !== m_miss[0])
                begin n_err++; $display("FAIL rnd_a_req c%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, a_en, a_pc, a_miss, m_en[0], m_pc[0], m_miss[0]); end
            n_chk++; if (a_flush !== m_flush[0][1:0] || a_kill !== m_kill[0][1:0])
                begin n_err++; $display("FAIL rnd_a_mask c%0d: got %0b/%0b want %0b/%0b", c, a_flush, a_kill, m_flush[0][1:0], m_kill[0][1:0]); end
            n_chk++; if (a_cnt !== 16'(m_cnt[0]) || a_busy !== (m_state[0] != 0))
                begin n_err++; $display("FAIL rnd_a_st c%0d: got cnt %0d busy %0h want %0d/%0h", c, a_cnt, a_busy, m_cnt[0], m_state[0] != 0); end
            n_chk++; if (b_en !== m_en[1] || b_pc !== m_pc[1] || b_miss !== m_miss[1])
                begin n_err++; $display("FAIL rnd_b_req c%0d: got %0h/%0h/%0h want %0h/%0h/%0h", c, b_en, b_pc, b_miss, m_en[1], m_pc[1], m_miss[1]); end
            n_chk++; if (b_flush !== m_flush[1] || b_kill !== m_kill[1])
                begin n_err++; $display("FAIL rnd_b_mask c%0d: got %0b/%0b want %0b/%0b", c, b_flush, b_kill, m_flush[1], m_kill[1]); end
            n_chk++; if (b_cnt !== 2'(m_cnt[1]) || b_busy !== (m_state[1] != 0))
                begin n_err++; $display("FAIL rnd_b_st c%0d: got cnt %0d busy %0h want %0d/%0h", c, b_cnt, b_busy, m_cnt[1], m_state[1] != 0); end
        end
        rstn = 1'b1;
        clr();
    endtask

    initial begin
        rstn = 1'b0;
        clr();
        test_reset();
        test_mispredict_nt();
        test_jump_after_nt();
        test_taken_stop();
        test_pend_hold();
        test_reset_in_pend();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/recover_unit_n.md
RECOVER_UNIT_N -- requirements
Module: recover_unit_n

Interface
REQ-001 The block SHALL have parameter ISSUE_W, default 2, giving the number of issue slots (legal 2..4); slot 0 is the oldest.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the PC width.
REQ-003 The block SHALL have parameter SHADOW_CYC, default 2, giving the cycles inputs are ignored after a redirect is acknowledged (legal 0..15).
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the width of the misprediction counter.
REQ-005 Ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- rstn  in  1  reset, synchronous, active-low.
- slot_valid  in  ISSUE_W  slot holds a resolved instruction.
- is_branch  in  ISSUE_W  conditional branch.
- is_jump  in  ISSUE_W  unconditional jump.
- taken  in  ISSUE_W  resolved branch direction.
- pred_taken  in  ISSUE_W  predicted branch direction.
- target_pc  in  ISSUE_W*XLEN  resolved target; slot i at bits [i*XLEN +: XLEN].
- original_pc  in  ISSUE_W*XLEN  instruction PC; same packing.
- recover_ack  in  1  PC control unit accepted the redirect.
- recover_en  out  1  redirect request pending.
- recover_pc  out  XLEN  redirect address.
- branch_predict_miss  out  1  redirect caused by a mispredicted branch.
- flush_onehot  out  ISSUE_W  redirecting slot.
- kill_mask  out  ISSUE_W  slots younger than the redirecting slot.
- miss_count  out  CNT_W  saturating count of captured mispredictions.
- busy  out  1  state is not IDLE.

Function
REQ-006 Slot evaluation SHALL scan from slot 0 upward and stop at the first valid slot matching a rule below; slots with slot_valid=0 are skipped.
REQ-007 A valid slot with is_jump=1 SHALL redirect with recover_pc=target_pc and miss=0; is_jump takes precedence over is_branch.
REQ-008 A valid branch with taken=1 and pred_taken=0 SHALL redirect with recover_pc=target_pc and miss=1.
REQ-009 A valid branch with taken=0 and pred_taken=1 SHALL redirect with recover_pc=original_pc+4 (mod 2^XLEN) and miss=1.
REQ-010 A valid branch with taken=1 and pred_taken=1 SHALL stop the scan with no redirect, because younger slots are already the correct path.
REQ-011 A correctly predicted not-taken branch or a non-control slot SHALL continue the scan.
REQ-012 The state machine SHALL have states IDLE, PEND and SHADOW.
REQ-013 In IDLE, when the scan finds a redirect, the block SHALL on the next edge register recover_pc, branch_predict_miss, flush_onehot (bit of the redirecting slot), kill_mask (all higher-index bits set), set recover_en=1, and go to PEND; capture latency is 1 cycle.
REQ-014 In IDLE with no redirect, all request outputs SHALL stay 0.
REQ-015 In PEND, all outputs SHALL hold stable and all slot inputs SHALL be ignored until recover_ack=1.
REQ-016 On recover_ack=1 in PEND, the next edge SHALL clear recover_en, recover_pc, branch_predict_miss, flush_onehot and kill_mask.
REQ-017 After that edge, the block SHALL go to SHADOW with the counter loaded to SHADOW_CYC-1, or go to IDLE if SHADOW_CYC=0.
REQ-018 In SHADOW, slot inputs SHALL be ignored; the counter SHALL decrement each cycle, and the block SHALL go to IDLE on the edge where the counter equals 0.
REQ-019 The total number of cycles spent in SHADOW SHALL be exactly SHADOW_CYC.
REQ-020 recover_ack in IDLE or SHADOW SHALL be ignored.
REQ-021 miss_count SHALL increment by 1 on each capture with miss=1 and saturate at 2^CNT_W-1.
REQ-022 busy SHALL be 1 in PEND and SHADOW.
REQ-023 flush_onehot SHALL never have more than one bit set.
REQ-024 flush_onehot SHALL be 0 whenever recover_en=0.

Reset
REQ-025 When rstn=0 at a rising clk edge, the block SHALL enter IDLE, clear the shadow counter and set all outputs to 0, including miss_count; this applies from any state, including mid-PEND and mid-SHADOW.
REQ-026 Slot inputs SHALL be ignored during any cycle with rstn=0.

Verification
REQ-027 Scenario: ISSUE_W=2, slot0 branch, taken=0, pred_taken=1, original_pc=0x100 -> one cycle later recover_en=1, recover_pc=0x104, miss=1, flush_onehot=01, kill_mask=10, miss_count=1.
REQ-028 Scenario: slot0 correctly predicted not-taken branch, slot1 jump with target 0x2000 -> recover_pc=0x2000, miss=0, flush_onehot=10, kill_mask=00.
REQ-029 Scenario: slot0 branch taken and predicted taken, slot1 mispredicted branch -> recover_en remains 0 and miss_count is unchanged.
REQ-030 Scenario: hold recover_ack=0 for 5 cycles while applying new mispredictions -> outputs remain frozen at the first capture; then ack=1 with SHADOW_CYC=2 -> busy=1 for 2 more cycles, then IDLE, and a misprediction presented during shadow is not captured.
REQ-031 Scenario: rstn=0 asserted during PEND -> on the next edge all outputs are 0 and state is IDLE; an immediate new misprediction after reset is captured normally.
REQ-032 Scenario: ISSUE_W=4, CNT_W=2, apply 5 separate misprediction/ack sequences -> miss_count saturates at 3; slot2 redirect gives flush_onehot=0100 and kill_mask=1000.
